// File: rtl/romix_seq_ctrl.sv
// ROMix sequencing controller.
// Runs the two scrypt ROMix phases over an external iteration counter:
//   write phase: for each i, store X into V[i] and launch BlockMix(X)
//   read phase : for each i, fetch V[j] and launch BlockMix(X xor V[j])
// The counter itself lives outside this block; it only sees cnt_en pulses.
// All strobes except cnt_en come straight from flops that hold the decode
// of the state being entered. cnt_en is a registered wait flag gated by
// mix_done, so it fires in the same cycle as the BlockMix completion.
module romix_seq_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] cnt,
    input  logic [ADDR_W-1:0] j_idx,
    input  logic              mix_done,
    output logic              cnt_en,
    output logic              mix_start,
    output logic              mix_xor,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_ISSUE = 3'd1,
        W_WAIT  = 3'd2,
        R_READ  = 3'd3,
        R_ISSUE = 3'd4,
        R_WAIT  = 3'd5,
        FIN     = 3'd6
    } state_t;

    // Per-state output image; registered alongside the state so that every
    // strobe is a flop output.
    typedef struct packed {
        logic ms;      // mix_start
        logic we;      // mem_we
        logic re;      // mem_re
        logic xr;      // mix_xor
        logic wt;      // waiting for mix_done (qualifies cnt_en)
        logic bsy;     // busy
        logic dn;      // done
        logic wsel;    // mem_addr follows cnt
        logic rsel;    // mem_addr follows j_idx
    } strobes_t;

    // Last iteration index; the counter is compared before it increments.
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    state_t   state_r;
    state_t   next_s;
    strobes_t out_r;
    logic     err_r;
    logic     reject_s;

    // Map a state to the strobe pattern it drives while it is current.
    function automatic strobes_t decode_state(input state_t s);
        strobes_t o;
        o = '0;
        case (s)
            IDLE: begin
                o = '0;
            end
            W_ISSUE: begin
                o.ms   = 1'b1;
                o.we   = 1'b1;
                o.wsel = 1'b1;
                o.bsy  = 1'b1;
            end
            W_WAIT: begin
                o.wt  = 1'b1;
                o.bsy = 1'b1;
            end
            R_READ: begin
                o.re   = 1'b1;
                o.rsel = 1'b1;
                o.bsy  = 1'b1;
            end
            R_ISSUE: begin
                o.ms  = 1'b1;
                o.xr  = 1'b1;
                o.bsy = 1'b1;
            end
            R_WAIT: begin
                o.wt  = 1'b1;
                o.xr  = 1'b1;
                o.bsy = 1'b1;
            end
            FIN: begin
                o.dn  = 1'b1;
                o.bsy = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

    // Next-state selection; a start is only honoured when the counter is at zero.
    always_comb begin
        next_s   = state_r;
        reject_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (cnt == '0)) begin
                    next_s = W_ISSUE;
                end else if (start) begin
                    reject_s = 1'b1;
                end else begin
                    next_s = IDLE;
                end
            end
            W_ISSUE: begin
                next_s = W_WAIT;
            end
            W_WAIT: begin
                if (mix_done && (cnt == LAST_IDX)) begin
                    next_s = R_READ;
                end else if (mix_done) begin
                    next_s = W_ISSUE;
                end else begin
                    next_s = W_WAIT;
                end
            end
            R_READ: begin
                next_s = R_ISSUE;
            end
            R_ISSUE: begin
                next_s = R_WAIT;
            end
            R_WAIT: begin
                if (mix_done && (cnt == LAST_IDX)) begin
                    next_s = FIN;
                end else if (mix_done) begin
                    next_s = R_READ;
                end else begin
                    next_s = R_WAIT;
                end
            end
            FIN: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State register plus the registered strobe image of the state being entered.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            out_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_s;
            out_r   <= decode_state(next_s);
            err_r   <= reject_s;
        end
    end

    // Scratchpad address: counter while writing, j_idx while reading, else zero.
    always_comb begin
        mem_addr = '0;
        if (out_r.wsel) begin
            mem_addr = cnt;
        end else if (out_r.rsel) begin
            mem_addr = j_idx;
        end else begin
            mem_addr = '0;
        end
    end

    assign cnt_en    = out_r.wt & mix_done;
    assign mix_start = out_r.ms;
    assign mix_xor   = out_r.xr;
    assign mem_we    = out_r.we;
    assign mem_re    = out_r.re;
    assign busy      = out_r.bsy;
    assign done      = out_r.dn;
    assign err       = err_r;

endmodule

// File: tb/tb_romix_seq_ctrl.sv
// Self-checking bench for romix_seq_ctrl (ADDR_W=2, N=4).
// The reference model works at iteration level: it counts completed
// BlockMix operations in a run and derives, from the ROMix rules, which
// strobes must appear in the following cycle. The bench also plays the
// external counter and a BlockMix responder with fixed or random latency.
module tb_romix_seq_ctrl;

    localparam int AW = 2;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          mix_done = 1'b0;
    logic [AW-1:0] cnt = '0;
    logic [AW-1:0] j_idx = '0;
    logic          cnt_en, mix_start, mix_xor, mem_we, mem_re, busy, done, err;
    logic [AW-1:0] mem_addr;

    romix_seq_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .RST(RST), .start(start), .cnt(cnt), .j_idx(j_idx),
        .mix_done(mix_done), .cnt_en(cnt_en), .mix_start(mix_start),
        .mix_xor(mix_xor), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // environment / model state
    int  cyc = 0;        // index of the cycle whose inputs are being applied
    int  due = -1;       // cycle in which the responder returns mix_done
    int  dly = 3;        // 0 = random latency
    int  slow_idx = -1;  // mix index (within a run) that takes 10 cycles
    int  mix_n = 0;
    int  jfix = 2;       // <0 = random j_idx every cycle
    bit  spur = 1'b0;    // inject stray mix_done when nothing is outstanding
    bit  real_done = 1'b0;
    int  k = 0;          // completed mixes in the current run
    bit  e_msw, e_msx, e_we, e_re, e_x, e_busy, e_done, e_err;
    logic [AW-1:0] e_waddr;

    bit  rec_on = 1'b0;
    int  t0 = 0;
    int  rec_ms[$], rec_we[$], rec_re[$], rec_ce[$], rec_dn[$], rec_bs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        e_msw = 1'b0; e_msx = 1'b0; e_we = 1'b0; e_re = 1'b0;
        e_x = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        e_waddr = '0; due = -1; k = 0; mix_n = 0;
    endtask

    task automatic rec_clear();
        rec_ms.delete(); rec_we.delete(); rec_re.delete();
        rec_ce.delete(); rec_dn.delete(); rec_bs.delete();
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
    task automatic tick(input bit st);
        bit acc, n_msw, n_we, n_re, n_done, n_err, ce_s;
        logic [AW-1:0] n_waddr;
        int d;
        start     = st;
        j_idx     = (jfix >= 0) ? AW'(jfix) : AW'($urandom);
        real_done = (due == cyc);
        mix_done  = real_done || (spur && (due < 0) && ($urandom_range(7) == 0));
        @(negedge clk);
        check("strobes", 32'({cnt_en, mix_start, mem_we, mem_re, mix_xor, busy, done, err}),
              32'({real_done, e_msw | e_msx, e_we, e_re, e_x, e_busy, e_done, e_err}));
        check("mem_addr", 32'(mem_addr),
              e_we ? 32'(e_waddr) : (e_re ? 32'(j_idx) : 32'd0));
        if (rec_on) begin
            if (mix_start) rec_ms.push_back(cyc - t0);
            if (mem_we)    rec_we.push_back(cyc - t0);
            if (mem_re)    rec_re.push_back(cyc - t0);
            if (cnt_en)    rec_ce.push_back(cyc - t0);
            if (done)      rec_dn.push_back(cyc - t0);
            if (busy)      rec_bs.push_back(cyc - t0);
        end
        ce_s = cnt_en;
        // BlockMix responder
        if (real_done) due = -1;
        if (mix_start) begin
            d = (mix_n == slow_idx) ? 10 : ((dly > 0) ? dly : int'($urandom_range(1, 12)));
            due = cyc + d;
            mix_n++;
        end
        // expectations for the next cycle
        acc = st && !e_busy && (cnt == '0);
        n_err = st && !e_busy && (cnt != '0);
        n_msw = 1'b0; n_we = 1'b0; n_re = 1'b0; n_done = 1'b0; n_waddr = '0;
        if (acc) begin
            k = 0; mix_n = 0; n_msw = 1'b1; n_we = 1'b1;
        end
        if (real_done) begin
            k++;
            if (k < N) begin
                n_msw = 1'b1; n_we = 1'b1; n_waddr = AW'(k);
            end else if (k < 2 * N) begin
                n_re = 1'b1;
            end else begin
                n_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cnt = cnt + AW'(ce_s);
        e_x    = e_re || (e_x && !real_done);
        e_msx  = e_re;
        e_busy = acc || (e_busy && !e_done);
        e_msw = n_msw; e_we = n_we; e_re = n_re; e_done = n_done;
        e_err = n_err; e_waddr = n_waddr;
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released after it.
    task automatic do_reset();
        #2;
        RST = 1'b1;
        start = 1'b0;
        mix_done = 1'b0;
        #1;
        check("rst_async", 32'({cnt_en, mix_start, mix_xor, mem_we, mem_re, busy, done, err, mem_addr}), 32'd0);
        cnt = '0;
        model_clear();
        @(posedge clk);
        #1;
        check("rst_hold", 32'({cnt_en, mix_start, mix_xor, mem_we, mem_re, busy, done, err, mem_addr}), 32'd0);
        RST = 1'b0;
        cyc++;
    endtask

    // Compare a recorded directed run (latency 3, j_idx 2) with the reference timeline.
    task automatic check_trace();
        int x_ms[8] = '{1, 5, 9, 13, 18, 23, 28, 33};
        int x_ce[8] = '{4, 8, 12, 16, 21, 26, 31, 36};
        int x_we[4] = '{1, 5, 9, 13};
        int x_re[4] = '{17, 22, 27, 32};
        check("n_mix_start", rec_ms.size(), 8);
        check("n_cnt_en", rec_ce.size(), 8);
        check("n_mem_we", rec_we.size(), 4);
        check("n_mem_re", rec_re.size(), 4);
        check("n_done", rec_dn.size(), 1);
        check("n_busy", rec_bs.size(), 37);
        for (int i = 0; i < 8; i++) begin
            if (i < rec_ms.size()) check("t_mix_start", rec_ms[i], x_ms[i]);
            if (i < rec_ce.size()) check("t_cnt_en", rec_ce[i], x_ce[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < rec_we.size()) check("t_mem_we", rec_we[i], x_we[i]);
            if (i < rec_re.size()) check("t_mem_re", rec_re[i], x_re[i]);
        end
        if (rec_dn.size() > 0) check("t_done", rec_dn[0], 37);
        if (rec_bs.size() > 0) check("t_busy_first", rec_bs[0], 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit_rst;
        int lim, rst_cyc;
        model_clear();
        RST = 1'b1;
        #1;
        check("reset_state", 32'({cnt_en, mix_start, mix_xor, mem_we, mem_re, busy, done, err, mem_addr}), 32'd0);
        @(posedge clk);
        #1;
        RST = 1'b0;

        // Directed run straight out of reset, with a stray start at cycle 6.
        rec_clear(); t0 = cyc; rec_on = 1'b1;
        for (int c = 0; c < 42; c++) tick((c == 0) || (c == 6));
        rec_on = 1'b0;
        check_trace();
        check("cnt_wrap", 32'(cnt), 32'd0);

        // Rejected start: counter not at zero.
        cnt = AW'(1);
        tick(1'b1);
        for (int c = 0; c < 3; c++) tick(1'b0);
        cnt = '0;
        tick(1'b0);

        // Reset at cycle 10 of a run, then an identical replay.
        t0 = cyc;
        for (int c = 0; c < 10; c++) tick(c == 0);
        do_reset();
        rec_clear(); t0 = cyc; rec_on = 1'b1;
        for (int c = 0; c < 42; c++) tick(c == 0);
        rec_on = 1'b0;
        check_trace();

        // Second mix of the run takes 10 cycles.
        slow_idx = 1;
        rec_clear(); t0 = cyc; rec_on = 1'b1;
        for (int c = 0; c < 50; c++) tick(c == 0);
        rec_on = 1'b0;
        slow_idx = -1;
        check("slow_cnt_en", rec_ce.size(), 8);
        check("slow_done", rec_dn.size(), 1);
        check("slow_mem_we", rec_we.size(), 4);

        // Randomized runs: random latency, j_idx, stray starts/mix_done, rejects, resets.
        dly = 0; jfix = -1; spur = 1'b1;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(3) == 0) begin
                cnt = AW'($urandom_range(1, N - 1));
                tick(1'b1);
                tick(1'b0);
                cnt = '0;
                tick(1'b0);
            end
            rst_cyc = ($urandom_range(4) == 0) ? int'($urandom_range(2, 60)) : -1;
            hit_rst = 1'b0;
            tick(1'b1);
            lim = 0;
            while (e_busy && (lim < 3000)) begin
                if (lim == rst_cyc) begin
                    do_reset();
                    hit_rst = 1'b1;
                    break;
                end
                tick($urandom_range(9) == 0);
                lim++;
            end
            if (e_busy && !hit_rst) begin
                n_vec++;
                n_bad++;
                $display("FAIL run_timeout: run %0d still busy after %0d cycles, expected idle", r, lim);
            end
            check("cnt_after_run", 32'(cnt), 32'd0);
            tick(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/romix_seq_ctrl.md
ROMIX_SEQ_CTRL -- requirements
Module: romix_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, scratchpad address width; N = 2^ADDR_W iterations per phase.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  single-cycle request to run one full ROMix.
REQ-005 SHALL have port cnt  in  ADDR_W  current value of the external up_counter_en iteration counter.
REQ-006 SHALL have port j_idx  in  ADDR_W  Integerify(X) mod N from the datapath, valid in read phase.
REQ-007 SHALL have port mix_done  in  1  single-cycle pulse: BlockMix result ready.
REQ-008 SHALL have port cnt_en  out  1  enable to the external counter, one-cycle pulse per iteration.
REQ-009 SHALL have port mix_start  out  1  one-cycle pulse launching BlockMix.
REQ-010 SHALL have port mix_xor  out  1  1 = BlockMix input is X xor V[j]; 0 = X.
REQ-011 SHALL have port mem_we  out  1  scratchpad write strobe (write X to V[mem_addr]).
REQ-012 SHALL have port mem_re  out  1  scratchpad read strobe; data valid the next cycle.
REQ-013 SHALL have port mem_addr  out  ADDR_W  scratchpad address.
REQ-014 SHALL have ports busy, done, err  out  1 each  running / one-cycle completion pulse / one-cycle rejected-start pulse.

Function
REQ-015 SHALL implement states IDLE, W_ISSUE, W_WAIT, R_READ, R_ISSUE, R_WAIT, FIN.
REQ-016 IDLE: start=1 and cnt==0 -> W_ISSUE; start=1 and cnt!=0 -> stay IDLE, err=1 next cycle for one cycle.
REQ-017 W_ISSUE (1 cycle): mem_we=1, mem_addr=cnt, mix_start=1, mix_xor=0 -> W_WAIT.
REQ-018 W_WAIT: on mix_done=1 assert cnt_en=1 same cycle; if cnt==N-1 -> R_READ else -> W_ISSUE; else hold.
REQ-019 R_READ (1 cycle): mem_re=1, mem_addr=j_idx -> R_ISSUE.
REQ-020 R_ISSUE (1 cycle): mix_start=1, mix_xor=1 -> R_WAIT.
REQ-021 R_WAIT: on mix_done=1 assert cnt_en=1 same cycle; if cnt==N-1 -> FIN else -> R_READ; else hold.
REQ-022 FIN (1 cycle): done=1 -> IDLE.
REQ-023 All strobes (cnt_en, mix_start, mem_we, mem_re, done, err) SHALL be registered-state decodes, high only in the states listed, never two cycles in a row from one event.
REQ-024 mix_xor SHALL be held at its state value throughout R_ISSUE/R_WAIT (1) and W_ISSUE/W_WAIT (0); 0 in IDLE/FIN.
REQ-025 mem_addr SHALL be 0 outside W_ISSUE and R_READ.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start while busy SHALL be ignored (no err); mix_done outside W_WAIT/R_WAIT SHALL be ignored.
REQ-028 Counter relies on natural wrap: after 2N cnt_en pulses cnt returns to 0; terminal test is cnt==N-1 compared before the increment.
REQ-029 Per run exactly 2N cnt_en pulses, N mem_we, N mem_re, 2N mix_start.

Reset
REQ-030 RST=1 SHALL asynchronously force IDLE and all outputs to 0, including mid-run; external counter is reset by the same RST so cnt==0 on release.
REQ-031 First start SHALL be accepted on the first rising edge after RST deasserts.

Verification (ADDR_W=2, N=4, mix_done fixed 3 cycles after mix_start)
REQ-032 start at cycle 0, cnt=0 -> mix_start+mem_we at 1,5,9,13 (mem_addr 0,1,2,3); cnt_en at 4,8,12,16.
REQ-033 Same run, j_idx=2 constant -> mem_re at 17,22,27,32 (mem_addr 2); mix_start+mix_xor at 18,23,28,33; cnt_en at 21,26,31,36; done=1 at 37 only; busy 1 from 1 to 37.
REQ-034 start with cnt=1 -> err=1 one cycle, busy stays 0, no strobes.
REQ-035 start pulsed at cycle 6 of a run -> no effect; trace identical to REQ-032/033.
REQ-036 RST at cycle 10 -> all outputs 0 immediately; new start after release replays REQ-032 timing offset.
REQ-037 mix_done delayed 10 cycles on iteration 2 -> FSM holds W_WAIT, no extra cnt_en, total cnt_en still 8.
